// File: rtl/fifo_uart_pkg.sv
// Shared state encoding for the fifo-to-UART transmitter.
package fifo_uart_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      IDLE   = 3'd0,
      ACK    = 3'd1,
      START  = 3'd2,
      DATA   = 3'd3,
      PARITY = 3'd4,
      STOP   = 3'd5
   } tx_state_e;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Receive-side handshake between the fifo (master) and the UART transmitter (slave).
interface fifo_uart_tx_if #(
   parameter int WIDTH = 8
);
   logic             rx_rdy;
   logic             rx_done;
   logic [WIDTH-1:0] in_data;

   modport master (output rx_rdy, output in_data, input rx_done);
   modport slave  (input rx_rdy, input in_data, output rx_done);
endinterface

// File: rtl/fifo_uart_tx_bit_timer.sv
// Bit-period divider: one-cycle bit_tick every CLKS_PER_BIT enabled cycles, restarted by clear.
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DIV_WIDTH    = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic bit_tick
);
   localparam logic [DIV_WIDTH-1:0] LAST = DIV_WIDTH'(CLKS_PER_BIT - 1);

   logic [DIV_WIDTH-1:0] div;

   assign bit_tick = enable && (div == LAST);

   // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           div <= '0;
      else if (clear)    div <= '0;
      else if (enable)   div <= bit_tick ? '0 : div + 1'b1;
   end
endmodule

// File: rtl/fifo_uart_tx.sv
// Pulls words from the fifo over a 4-phase handshake and sends them LSB-first as UART frames.
// Define FIFO_UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int WIDTH         = 8,
   parameter int CLKS_PER_BIT  = 16,
   parameter int DIV_WIDTH     = 5,
   parameter int BIT_CNT_WIDTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   fifo_uart_tx_if.slave rx,
   output logic          tx_line,
   output logic          busy
);
   tx_state_e                state_q, state_d;
   logic [WIDTH-1:0]         shift_q, shift_d;
   logic [BIT_CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                     done_q, done_d;
   logic                     tx_q, tx_d;
   logic                     busy_q, busy_d;
   logic                     bit_tick, timer_clear, timer_en, last_bit;
`ifdef FIFO_UART_TX_PARITY_EN
   logic                     par_q, par_d;
`endif

   assign last_bit    = (cnt_q == BIT_CNT_WIDTH'(WIDTH - 1));
   assign timer_clear = (state_q == ACK) && !rx.rx_rdy;
   assign timer_en    = (state_q != IDLE) && (state_q != ACK);

   uart_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .DIV_WIDTH    (DIV_WIDTH)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    (timer_clear),
      .enable   (timer_en),
      .bit_tick (bit_tick)
   );

   // NOTE: the shift register is reset along with control so a frame never starts from stale data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
`ifdef FIFO_UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   // NOTE: defaulting every output of a combinational block first prevents latch inference.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:   if (rx.rx_rdy)  state_d = ACK;
         ACK:    if (!rx.rx_rdy) state_d = START;
         START:  if (bit_tick)   state_d = DATA;
`ifdef FIFO_UART_TX_PARITY_EN
         DATA:   if (bit_tick && last_bit) state_d = PARITY;
         PARITY: if (bit_tick)   state_d = STOP;
`else
         DATA:   if (bit_tick && last_bit) state_d = STOP;
`endif
         STOP:   if (bit_tick)   state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
`ifdef FIFO_UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      unique case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (rx.rx_rdy) begin
               shift_d = rx.in_data;
               done_d  = 1'b1;
               busy_d  = 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
               par_d   = ^rx.in_data;
`endif
            end
         end
         // Data is captured only in IDLE; the fifo may change in_data once rx_done is seen.
         ACK: if (!rx.rx_rdy) begin
            done_d = 1'b0;
            tx_d   = 1'b0;
         end
         START: if (bit_tick) begin
            tx_d  = shift_q[0];
            cnt_d = '0;
         end
         DATA: if (bit_tick) begin
            if (last_bit) begin
`ifdef FIFO_UART_TX_PARITY_EN
               tx_d = par_q;
`else
               tx_d = 1'b1;
`endif
            end else begin
               shift_d = shift_q >> 1;
               tx_d    = shift_d[0];
               cnt_d   = cnt_q + 1'b1;
            end
         end
`ifdef FIFO_UART_TX_PARITY_EN
         PARITY: if (bit_tick) tx_d = 1'b1;
`endif
         STOP: if (bit_tick) busy_d = 1'b0;
         default: ;
      endcase
   end

   assign rx.rx_done = done_q;
   assign tx_line    = tx_q;
   assign busy       = busy_q;
endmodule
